// File: rtl/pga_gain_sched.sv
// PGA gain-code write scheduler: arbitrates host and AGC requests, clamps codes,
// and drives a level-based set/ready handshake with hold-off pacing and timeout.
module pga_gain_sched #(
    parameter int CODE_W      = 8,
    parameter int MIN_CODE    = 0,
    parameter int MAX_CODE    = 255,
    parameter int HOLDOFF_CYC = 1024,
    parameter int TIMEOUT_CYC = 4096,
    parameter int RESET_CODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req_i,
    input  logic [CODE_W-1:0] host_code_i,
    output logic              host_ack_o,
    input  logic              agc_req_i,
    input  logic [CODE_W-1:0] agc_code_i,
    output logic              agc_ack_o,
    input  logic              agc_lock_i,
    input  logic              pga_ready_i,
    output logic              pga_set_o,
    output logic [CODE_W-1:0] pga_code_o,
    output logic [CODE_W-1:0] cur_code_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam int CNT_MAX  = (HOLDOFF_CYC > TIMEOUT_CYC) ? HOLDOFF_CYC : TIMEOUT_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;
    localparam int CODE_TOP = (1 << CODE_W) - 1;

    localparam logic [CODE_W-1:0] MIN_C     = CODE_W'(MIN_CODE);
    localparam logic [CODE_W-1:0] MAX_C     = CODE_W'(MAX_CODE);
    localparam logic [CODE_W-1:0] RST_C     = CODE_W'(RESET_CODE);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_HOLDOFF
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              rdy_seen_reg;
    logic              pga_set_reg;
    logic              busy_reg;
    logic              err_reg;
    logic [CODE_W-1:0] pga_code_reg;
    logic [CODE_W-1:0] cur_code_reg;

    // Index 0 is the host port, index 1 the AGC port.
    logic [CODE_W-1:0] req_code   [2];
    logic [CODE_W-1:0] clamp_code [2];

    assign req_code[0] = host_code_i;
    assign req_code[1] = agc_code_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
            logic below;
            logic above;
            if (MIN_CODE > 0) begin : g_lo
                assign below = req_code[gi] < MIN_C;
            end else begin : g_lo_none
                assign below = 1'b0;
            end
            if (MAX_CODE < CODE_TOP) begin : g_hi
                assign above = req_code[gi] > MAX_C;
            end else begin : g_hi_none
                assign above = 1'b0;
            end
            assign clamp_code[gi] = below ? MIN_C : (above ? MAX_C : req_code[gi]);
        end
    endgenerate

    logic              host_win;
    logic              agc_win;
    logic              win_write;
    logic [CODE_W-1:0] win_code;

    // Acks are combinational so the requester sees them in the cycle it is served.
    always_comb begin
        host_win  = (state_reg == S_IDLE) && host_req_i;
        agc_win   = (state_reg == S_IDLE) && agc_req_i && !host_req_i;
        win_code  = host_req_i ? clamp_code[0] : clamp_code[1];
        win_write = (host_win || (agc_win && !agc_lock_i)) && (win_code != cur_code_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_INIT;
            cnt_reg      <= '0;
            rdy_seen_reg <= 1'b0;
            pga_set_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            pga_code_reg <= RST_C;
            cur_code_reg <= RST_C;
        end else begin
            case (state_reg)
                S_INIT: begin
                    state_reg    <= S_ISSUE;
                    pga_set_reg  <= 1'b1;
                    pga_code_reg <= RST_C;
                    busy_reg     <= 1'b1;
                    cnt_reg      <= '0;
                    rdy_seen_reg <= pga_ready_i;
                end
                S_IDLE: begin
                    if (win_write) begin
                        state_reg    <= S_ISSUE;
                        pga_set_reg  <= 1'b1;
                        pga_code_reg <= win_code;
                        busy_reg     <= 1'b1;
                        cnt_reg      <= '0;
                        rdy_seen_reg <= pga_ready_i;
                    end
                end
                S_ISSUE: begin
                    // A falling ready only counts once ready has been seen high,
                    // so a still-busy interface is not mistaken for an accept.
                    if (rdy_seen_reg && !pga_ready_i) begin
                        state_reg   <= S_WAIT_DONE;
                        pga_set_reg <= 1'b0;
                        cnt_reg     <= '0;
                    end else if (cnt_reg == TMO_LAST) begin
                        state_reg   <= S_HOLDOFF;
                        pga_set_reg <= 1'b0;
                        err_reg     <= 1'b1;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (pga_ready_i) begin
                            rdy_seen_reg <= 1'b1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (pga_ready_i) begin
                        state_reg    <= S_HOLDOFF;
                        cur_code_reg <= pga_code_reg;
                        cnt_reg      <= '0;
                    end else if (cnt_reg == TMO_LAST) begin
                        state_reg <= S_HOLDOFF;
                        err_reg   <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg   <= S_INIT;
                    pga_set_reg <= 1'b0;
                end
            endcase
        end
    end

    assign host_ack_o = host_win;
    assign agc_ack_o  = agc_win;
    assign pga_set_o  = pga_set_reg;
    assign pga_code_o = pga_code_reg;
    assign cur_code_o = cur_code_reg;
    assign busy_o     = busy_reg;
    assign err_o      = err_reg;

endmodule

// File: tb/tb_pga_gain_sched.sv
// Randomized bench for pga_gain_sched: a transaction-level reference model plus
// a behavioural PGA responder predict acks, writes, hold-off and timeouts.
module tb_pga_gain_sched;
    localparam int CODE_W    = 8;
    localparam int MIN_CODE  = 8;
    localparam int MAX_CODE  = 200;
    localparam int HC        = 16;
    localparam int TO        = 64;
    localparam int RST_CODE  = 16;
    localparam int RUN_CYC   = 6000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_req = 1'b0;
    logic [CODE_W-1:0] host_code = '0;
    logic              host_ack;
    logic              agc_req = 1'b0;
    logic [CODE_W-1:0] agc_code = '0;
    logic              agc_ack;
    logic              agc_lock = 1'b0;
    logic              pga_ready = 1'b1;
    logic              pga_set;
    logic [CODE_W-1:0] pga_code;
    logic [CODE_W-1:0] cur_code;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    pga_gain_sched #(
        .CODE_W      (CODE_W),
        .MIN_CODE    (MIN_CODE),
        .MAX_CODE    (MAX_CODE),
        .HOLDOFF_CYC (HC),
        .TIMEOUT_CYC (TO),
        .RESET_CODE  (RST_CODE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_req_i  (host_req),
        .host_code_i (host_code),
        .host_ack_o  (host_ack),
        .agc_req_i   (agc_req),
        .agc_code_i  (agc_code),
        .agc_ack_o   (agc_ack),
        .agc_lock_i  (agc_lock),
        .pga_ready_i (pga_ready),
        .pga_set_o   (pga_set),
        .pga_code_o  (pga_code),
        .cur_code_o  (cur_code),
        .busy_o      (busy),
        .err_o       (err)
    );

    typedef struct {
        bit host_en;
        int host_c;
        bit agc_en;
        int agc_c;
        bit lock;
        bit stall;
    } txn_t;

    txn_t txq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    endtask

    function automatic int clampc(input int c);
        if (c < MIN_CODE) return MIN_CODE;
        if (c > MAX_CODE) return MAX_CODE;
        return c;
    endfunction

    // Model: phase 0 idle, 1 set asserted, 2 PGA busy (ready low), 3 hold-off.
    int   phase = 0;
    int   cnt = 0;
    bit   wr_stall = 0;
    bit   stall_pend = 0;
    int   wr_code = RST_CODE;
    int   m_cur = RST_CODE;
    int   m_code = RST_CODE;
    bit   m_err = 0;
    bit   drop_h = 0;
    bit   drop_a = 0;
    int   gap = 0;
    int   n_txn = 0;

    function automatic int pick_code();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 255;
            2, 3: return m_cur;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   sel;
        sel       = int'($urandom_range(1, 3));
        t.host_en = sel[0];
        t.agc_en  = sel[1];
        t.host_c  = pick_code();
        t.agc_c   = pick_code();
        t.lock    = ($urandom_range(0, 3) == 0);
        t.stall   = ($urandom_range(0, 15) == 0);
        return t;
    endfunction

    // Called at a falling edge; returns at the falling edge where reset is released.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_set", 32'(pga_set), 32'(0));
        chk("rst_code", 32'(pga_code), 32'(RST_CODE));
        chk("rst_cur", 32'(cur_code), 32'(RST_CODE));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        host_req  = 1'b0;
        agc_req   = 1'b0;
        pga_ready = 1'b1;
        drop_h    = 0;
        drop_a    = 0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'({host_ack, agc_ack}), 32'(0));
        rst_n      = 1'b1;
        phase      = 1;
        cnt        = int'($urandom_range(0, 4));
        wr_code    = RST_CODE;
        m_code     = RST_CODE;
        m_cur      = RST_CODE;
        m_err      = 0;
        wr_stall   = 0;
        stall_pend = 0;
        $display("reset released: PGA rewrite of 0x%02h expected", RST_CODE);
    endtask

    task automatic sample_and_model();
        bit    idle;
        bit    eh;
        bit    ea;
        int    c;
        string who;
        idle = (phase == 0);
        eh   = idle && host_req;
        ea   = idle && agc_req && !host_req;
        chk("ack", 32'({host_ack, agc_ack}), 32'({eh, ea}));
        chk("set", 32'(pga_set), 32'(phase == 1));
        chk("code", 32'(pga_code), 32'(m_code));
        chk("cur", 32'(cur_code), 32'(m_cur));
        chk("busy", 32'(busy), 32'(!idle));
        chk("err", 32'(err), 32'(m_err));
        case (phase)
            0: begin
                if (eh || ea) begin
                    c   = eh ? clampc(int'(host_code)) : clampc(int'(agc_code));
                    who = eh ? "host" : "agc";
                    if (eh) drop_h = 1;
                    else    drop_a = 1;
                    n_txn++;
                    if (ea && agc_lock) begin
                        $display("txn %0d: agc 0x%02h discarded (lock)", n_txn, agc_code);
                    end else if (c == m_cur) begin
                        $display("txn %0d: %s code %0d equals current, skipped", n_txn, who, c);
                    end else begin
                        phase      = 1;
                        wr_stall   = stall_pend;
                        cnt        = stall_pend ? TO - 1 : int'($urandom_range(0, 6));
                        stall_pend = 0;
                        wr_code    = c;
                        m_code     = c;
                        $display("txn %0d: %s write %0d%s", n_txn, who, c,
                                 wr_stall ? " (PGA stalled)" : "");
                    end
                end
            end
            1: begin
                if (cnt == 0) begin
                    if (wr_stall) begin
                        m_err = 1;
                        phase = 3;
                        cnt   = HC;
                    end else begin
                        pga_ready = 1'b0;
                        phase     = 2;
                        cnt       = int'($urandom_range(0, 20));
                    end
                end else begin
                    cnt--;
                end
            end
            2: begin
                if (cnt == 0) begin
                    pga_ready = 1'b1;
                    m_cur     = wr_code;
                    phase     = 3;
                    cnt       = HC;
                end else begin
                    cnt--;
                end
            end
            default: begin
                cnt--;
                if (cnt == 0) phase = 0;
            end
        endcase
    endtask

    // Requester side: drops after an ack and new requests change just after the edge.
    task automatic drive_requests();
        txn_t t;
        if (drop_h) begin host_req = 1'b0; drop_h = 0; end
        if (drop_a) begin agc_req = 1'b0; drop_a = 0; end
        if (!host_req && !agc_req) begin
            if (gap > 0) begin
                gap--;
            end else begin
                if (txq.size() > 0) t = txq.pop_front();
                else                t = rand_txn();
                host_req   = t.host_en;
                host_code  = CODE_W'(t.host_c);
                agc_req    = t.agc_en;
                agc_code   = CODE_W'(t.agc_c);
                agc_lock   = t.lock;
                stall_pend = t.stall;
                gap        = int'($urandom_range(0, 30));
            end
        end
    endtask

    initial begin
        txq.push_back('{1, 'h40, 0, 0, 0, 0});
        txq.push_back('{1, 'h20, 1, 'h30, 0, 0});
        txq.push_back('{0, 0, 1, 'hFF, 0, 0});
        txq.push_back('{0, 0, 1, 'h02, 0, 0});
        txq.push_back('{0, 0, 1, 'hFF, 0, 0});
        txq.push_back('{0, 0, 1, 200, 0, 0});
        txq.push_back('{0, 0, 1, 'h55, 1, 0});
        txq.push_back('{1, 'h55, 0, 0, 1, 0});
        txq.push_back('{1, 'h99, 0, 0, 0, 1});

        @(negedge clk);
        do_reset();
        for (int cyc = 0; cyc < RUN_CYC && (n_checks - n_pass) < 50; cyc++) begin
            @(posedge clk);
            #1;
            drive_requests();
            @(negedge clk);
            sample_and_model();
            if (phase == 0 && m_err) begin
                do_reset();
            end else if (phase != 0 && $urandom_range(0, 499) == 0) begin
                do_reset();
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
